// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared defaults and types for the sprite ROM arbiter: requester count, ROM geometry, tag layout.
package sprite_arb_pkg;
  localparam int N_REQ    = 4;
  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 4;
  localparam int ROM_LAT  = 1;
  localparam int REQ_ID_W = $clog2(N_REQ);

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;
endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index strictly after ptr, wrapping.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   eligible,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] winner
);
  logic [IDW-1:0] idx;

  // Scan farthest-first so the nearest hit after ptr overwrites earlier ones.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM port; returns data to the
// granted requester ROM_LAT+1 cycles after its grant, tagged through a valid/id pipeline.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ   = sprite_arb_pkg::N_REQ,
  parameter int ADDR_W  = sprite_arb_pkg::ADDR_W,
  parameter int DATA_W  = sprite_arb_pkg::DATA_W,
  parameter int ROM_LAT = sprite_arb_pkg::ROM_LAT
) (
  input  logic                    vga_clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } arb_tag_t;

  logic [IDW-1:0]    ptr, win;
  logic              found;
  logic [N_REQ-1:0]  eligible;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] q_hold;
  arb_tag_t [ROM_LAT:0] tag_pipe;

  // Masking the current grantee stops a double grant before it drops req.
  assign eligible = req & ~gnt;
  assign win_addr = addr[win*ADDR_W +: ADDR_W];

  rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .found    (found),
    .winner   (win)
  );

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= ROM_LAT; i++) busy = busy | tag_pipe[i].valid;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      gnt      <= '0;
      rom_addr <= '0;
      ptr      <= IDW'(N_REQ - 1);
      tag_pipe <= '0;
      q_hold   <= '0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      gnt <= found ? (N_REQ'(1) << win) : '0;
      if (found) rom_addr <= win_addr;
      if (frame_start)  ptr <= IDW'(N_REQ - 1);
      else if (found)   ptr <= win;

      tag_pipe[0] <= {found, win};
      for (int i = 1; i <= ROM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

      // rom_q is only valid for a given address on the edge its tag enters the
      // last stage; later grants would overwrite it, so latch it one stage early.
      q_hold <= rom_q;
      if (tag_pipe[ROM_LAT].valid) begin
        rdata  <= q_hold;
        rvalid <= N_REQ'(1) << tag_pipe[ROM_LAT].id;
      end else begin
        rvalid <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized + directed bench for sprite_rom_arbiter against a grant-history reference model.
module tb_sprite_rom_arbiter;
  localparam int N   = 4;
  localparam int AW  = 17;
  localparam int DW  = 4;
  localparam int RL  = 1;
  localparam int LAT = RL + 1;
  localparam int HN  = 2048;

  logic            vga_clk, reset, frame_start;
  logic [N-1:0]    req, gnt, rvalid;
  logic [N*AW-1:0] addr;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_q, rdata;
  logic            busy;
  logic [AW-1:0]   a [N];

  int errors = 0, checks = 0;

  // reference model state
  int            n = LAT;
  int            m_ptr;
  logic [N-1:0]  m_gnt, exp_rvalid;
  logic [AW-1:0] m_rom_addr;
  logic [DW-1:0] m_rdata;
  logic          exp_busy;
  bit            hv   [HN];
  int            hid  [HN];
  logic [AW-1:0] haddr[HN];

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(RL)) dut (
    .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start), .req(req),
    .addr(addr), .gnt(gnt), .rom_addr(rom_addr), .rom_q(rom_q),
    .rvalid(rvalid), .rdata(rdata), .busy(busy)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  always_comb begin
    addr = '0;
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = a[i];
  end

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] x);
    logic [31:0] h;
    h = (32'(x) * 32'h9E37) ^ (32'(x) >> 5);
    return h[DW-1:0];
  endfunction

  // ROM clocked on the inverted pixel clock
  always @(negedge vga_clk) rom_q <= rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", tag, n, got, exp);
    end
  endtask

  // Advance one edge: predict from the rules, then compare after the edge.
  task automatic tick();
    int w;
    bit f;
    n++;
    exp_rvalid = '0;
    if (reset) begin
      m_gnt = '0; m_rom_addr = '0; m_ptr = N - 1; m_rdata = '0;
      for (int k = 0; k < LAT; k++) hv[n-k] = 0;
    end else begin
      f = 0; w = 0;
      for (int k = 1; k <= N && !f; k++)
        if (req[(m_ptr + k) % N] && !m_gnt[(m_ptr + k) % N]) begin
          f = 1; w = (m_ptr + k) % N;
        end
      hv[n] = f; hid[n] = w; haddr[n] = a[w];
      m_gnt = f ? N'(1) << w : '0;
      if (f) m_rom_addr = a[w];
      if (frame_start) m_ptr = N - 1;
      else if (f)      m_ptr = w;
      if (hv[n-LAT]) begin
        exp_rvalid = N'(1) << hid[n-LAT];
        m_rdata    = rom_fn(haddr[n-LAT]);
      end
    end
    exp_busy = 1'b0;
    for (int k = 0; k < LAT; k++) exp_busy = exp_busy | hv[n-k];
    @(posedge vga_clk);
    #1;
    chk("gnt",      32'(gnt),      32'(m_gnt));
    chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    chk("rvalid",   32'(rvalid),   32'(exp_rvalid));
    chk("rdata",    32'(rdata),    32'(m_rdata));
    chk("busy",     32'(busy),     32'(exp_busy));
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; req = '0;
    for (int i = 0; i < N; i++) a[i] = '0;
    repeat (3) tick();
    reset = 1'b0;

    // single read from requester 0
    req = 4'b0001; a[0] = 17'h00123; tick();
    req = '0; repeat (3) tick();

    // all requesters, distinct addresses
    for (int i = 0; i < N; i++) a[i] = AW'(17'h01000 + i * 17'h111);
    req = 4'b1111; repeat (8) tick();
    req = '0; repeat (3) tick();

    // lone requester 2 held continuously
    a[2] = 17'h1ABCD; req = 4'b0100; repeat (6) tick();
    req = '0; repeat (3) tick();

    // ptr at 1, then frame_start on the edge that grants 3
    req = 4'b0010; a[1] = 17'h00042; tick();
    req = 4'b1010; a[1] = 17'h00043; a[3] = 17'h0F00D; frame_start = 1'b1; tick();
    frame_start = 1'b0; req = 4'b0010; tick();
    req = '0; repeat (3) tick();

    // reset one cycle after a grant discards the in-flight read
    req = 4'b0001; a[0] = 17'h00777; tick();
    req = '0; reset = 1'b1; tick();
    reset = 1'b0; repeat (3) tick();

    // idle
    repeat (5) tick();

    // randomized protocol-respecting traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_gnt[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          a[i]   = AW'($urandom);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          a[i]   = AW'($urandom);
        end
      end
      frame_start = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 60) == 0);
      tick();
    end
    reset = 1'b0; frame_start = 1'b0; req = '0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite/background ROM read port among N_REQ pixel-fetch requesters (background, player jets, bullets).
- Round-robin arbitration, one ROM read issued per vga_clk cycle.
- Read data is returned to the winning requester with a fixed latency and a per-requester valid pulse.
- Sits between the per-layer address generators and the shared ROM; its output data feeds the palette lookup.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 17, ROM address width
- DATA_W, 4, ROM word width (palette index)
- ROM_LAT, 1, cycles from rom_addr register update to valid rom_q (ROM clocked on inverted vga_clk gives 1)

Ports:
- vga_clk  in  1  system pixel clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of frame; resets the round-robin pointer
- req  in  N_REQ  request per requester; held high with a stable addr until the granting cycle
- addr  in  N_REQ*ADDR_W  flattened request addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot grant pulse, registered
- rom_addr  out  ADDR_W  registered address to the ROM
- rom_q  in  DATA_W  ROM output data
- rvalid  out  N_REQ  one-hot, one-cycle data-valid pulse for the owner of rdata
- rdata  out  DATA_W  registered read data
- busy  out  1  high while any read is in flight in the tag pipeline

Behaviour:
- Reset values:
  - gnt=0, rvalid=0, rdata=0, rom_addr=0, busy=0
  - ptr=N_REQ-1, so requester 0 wins first
  - tag pipeline cleared
- Eligibility at each edge: eligible[i] = req[i] & ~gnt[i]. The requester granted in the current cycle is masked, which prevents a double grant while it has not yet dropped req.
- Arbitration: search eligible indices from ptr+1 upward, wrapping modulo N_REQ. The first hit is winner w.
- On a win, at the edge:
  - gnt <= onehot(w)
  - rom_addr <= addr[w]
  - ptr <= w
  - push tag {1, w}
- With no eligible requester: gnt <= 0, rom_addr holds, ptr holds, push tag {0, x}.
- Tag pipeline: ROM_LAT+1 stages. Stage 0 is loaded with the pushed tag.
- When the last stage holds a valid tag:
  - rdata <= rom_q, sampled ROM_LAT cycles after rom_addr was loaded
  - rvalid <= onehot(id) for one cycle; otherwise rvalid <= 0 and rdata holds
- Latency: gnt[w] is high in cycle G; rvalid[w] is high in cycle G+ROM_LAT+1, which is G+2 by default. Throughput is one read per cycle.
- Requester protocol:
  - Deassert req, or present a new addr, at the edge ending the gnt cycle.
  - A requester is granted at most every other cycle.
  - With 2 or more active requesters, grants interleave.
- Fairness: a continuously requesting requester waits at most N_REQ-1 grants.
- frame_start:
  - At the edge it is sampled, ptr <= N_REQ-1. This overrides ptr <= w in the same edge.
  - Arbitration in that same edge still uses the old ptr.
  - In-flight tags are unaffected.
- busy = OR of the tag valid bits across all stages.
- Reset mid-operation: pending tags are discarded, and no rvalid is produced for reads granted before reset.
- All-requesters-active with N_REQ=4: the grant sequence is 0,1,2,3,0,...
  - This holds because the masked requester is always the last winner, so the pointer skips it anyway.
- Single requester held high continuously: granted every other cycle (G, G+2, ...).

Decomposition:
- Package sprite_arb_pkg holds:
  - N_REQ, ADDR_W, DATA_W, ROM_LAT defaults
  - REQ_ID_W = $clog2(N_REQ)
  - typedef req_id_t
  - typedef tag_t (struct packed {valid, id})
- Sub-module rr_pick: purely combinational round-robin priority picker.
  - Inputs: eligible vector and ptr.
  - Outputs: found and winner id.
- Sequencing, registers and the tag pipeline stay in sprite_rom_arbiter.

Test Plan:
- Reset, then req=4'b0001 with addr0=17'h00123 → gnt=4'b0001 one cycle after the edge, rom_addr=17'h00123, rvalid=4'b0001 two cycles later with rdata equal to ROM[0x123], busy high across the flight.
- req=4'b1111 held 8 cycles with distinct addresses → gnt order 0,1,2,3,0,1,2,3; rvalid follows the same order two cycles later; each rdata matches its address.
- Only req[2] held high continuously → gnt[2] on alternate cycles; rvalid[2] on alternate cycles; no duplicate reads.
- req=4'b1010 with ptr at 1, frame_start pulsed in the same cycle as the grant to 3 → the next grant after requester 3 releases goes to requester 1 (pointer reset), and the in-flight read to 3 still returns with rvalid[3].
- Reset asserted one cycle after gnt[0] → no rvalid in the following 3 cycles; busy=0, rom_addr=0.
- req=0 for 5 cycles → gnt=0, rvalid=0, rom_addr and rdata stable, busy=0.
